// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// control_types
// Shared types for the pipeline control slice:
//   reg_wr_src_t       write-back source select of an instruction
//   pipe_ctrl_state_t  hazard-controller FSM states
//   idx_hit()          "source operand really reads this destination" compare
// -----------------------------------------------------------------------------
package control_types;

    typedef enum logic [1:0] {
        WRSRC_ALU     = 2'd0,
        WRSRC_MEMREAD = 2'd1,
        WRSRC_PC      = 2'd2,
        WRSRC_IMM     = 2'd3
    } reg_wr_src_t;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_ctrl_state_t;

    // A source operand only creates a dependency when it is actually read.
    function automatic logic idx_hit(input logic       used,
                                     input logic [4:0] src_idx,
                                     input logic [4:0] dst_idx);
        return used && (src_idx == dst_idx);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the datapath and the stall/flush sequencer.
//   master : datapath side (drives hazard inputs, receives enables/clears)
//   slave  : sequencer side (pipeline_hazard_ctrl)
// stall_cycles / flush_count exist only when PIPE_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;

    logic [4:0]                rs1_idx_id;
    logic [4:0]                rs2_idx_id;
    logic                      rs1_used_id;
    logic                      rs2_used_id;
    logic [4:0]                wr_reg_idx_ex;
    logic                      reg_do_write_ctrl_ex;
    control_types::reg_wr_src_t reg_wr_src_ctrl_ex;
    logic                      branch_taken_ex;
    logic                      dmem_req_mem;
    logic                      dmem_ready_mem;

    logic                      pc_enable;
    logic                      if_id_enable;
    logic                      id_ex_enable;
    logic                      ex_mem_enable;
    logic                      mem_wb_enable;
    logic                      if_id_clear;
    logic                      id_ex_clear;
    logic                      ex_mem_clear;
    logic                      mem_wb_clear;
    logic                      mem_timeout_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]               stall_cycles;
    logic [31:0]               flush_count;
`endif

    modport master (
`ifdef PIPE_CTRL_PERF_EN
        input  stall_cycles, flush_count,
`endif
        output rs1_idx_id, rs2_idx_id, rs1_used_id, rs2_used_id,
               wr_reg_idx_ex, reg_do_write_ctrl_ex, reg_wr_src_ctrl_ex,
               branch_taken_ex, dmem_req_mem, dmem_ready_mem,
        input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
               if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, mem_timeout_err
    );

    modport slave (
`ifdef PIPE_CTRL_PERF_EN
        output stall_cycles, flush_count,
`endif
        input  rs1_idx_id, rs2_idx_id, rs1_used_id, rs2_used_id,
               wr_reg_idx_ex, reg_do_write_ctrl_ex, reg_wr_src_ctrl_ex,
               branch_taken_ex, dmem_req_mem, dmem_ready_mem,
        output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
               if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, mem_timeout_err
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector: the EX instruction is a load whose
// result the ID instruction needs next cycle.
//   inputs : ID source indices/used flags, EX destination, write enable, source
//   output : load_use
// x0 is never a real dependency since it is hard-wired to zero.
// -----------------------------------------------------------------------------
module hazard_detect
    import control_types::*;
(
    input  logic [4:0]  rs1_idx_id,
    input  logic [4:0]  rs2_idx_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic [4:0]  wr_reg_idx_ex,
    input  logic        reg_do_write_ctrl_ex,
    input  reg_wr_src_t reg_wr_src_ctrl_ex,
    output logic        load_use
);

    always_comb begin
        load_use = reg_do_write_ctrl_ex
                 && (reg_wr_src_ctrl_ex == WRSRC_MEMREAD)
                 && (wr_reg_idx_ex != 5'd0)
                 && (idx_hit(rs1_used_id, rs1_idx_id, wr_reg_idx_ex)
                     || idx_hit(rs2_used_id, rs2_idx_id, wr_reg_idx_ex));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pipeline_hazard_ctrl_if.slave (hazard inputs in, PC/pipeline
//              register enables and clears out, sticky watchdog error out)
// Parameters: FLUSH_CYCLES (post-reset clearing cycles), MEM_TIMEOUT (watchdog).
// Optional macro PIPE_CTRL_PERF_EN adds stall_cycles / flush_count counters.
// Outputs are combinational from state and inputs (zero added latency).
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import control_types::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

    pipe_ctrl_state_t   state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic mem_stall;
    logic load_use;
    logic branch_flush;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;

    hazard_detect u_hazard_detect (
        .rs1_idx_id           (bus.rs1_idx_id),
        .rs2_idx_id           (bus.rs2_idx_id),
        .rs1_used_id          (bus.rs1_used_id),
        .rs2_used_id          (bus.rs2_used_id),
        .wr_reg_idx_ex        (bus.wr_reg_idx_ex),
        .reg_do_write_ctrl_ex (bus.reg_do_write_ctrl_ex),
        .reg_wr_src_ctrl_ex   (bus.reg_wr_src_ctrl_ex),
        .load_use             (load_use)
    );

    // dmem_ready_mem only matters while a request is outstanding.
    assign mem_stall = bus.dmem_req_mem & ~bus.dmem_ready_mem;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        branch_flush  = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_clr     = 1'b0;
        id_ex_clr     = 1'b0;
        ex_mem_clr    = 1'b0;
        mem_wb_clr    = 1'b0;

        case (state_q)
            RUN, MEM_WAIT: begin
                // Memory stall freezes everything up to EX, so a pending
                // branch or load-use simply waits and is decoded on release.
                if (mem_stall) begin
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_ex_en   = 1'b0;
                    ex_mem_en  = 1'b0;
                    mem_wb_clr = 1'b1;
                end else if (bus.branch_taken_ex) begin
                    // Squashing ID also discards any load-use it carried.
                    if_id_clr    = 1'b1;
                    id_ex_clr    = 1'b1;
                    branch_flush = 1'b1;
                end else if (load_use) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_clr = 1'b1;
                end

                if (state_q == RUN) begin
                    if (mem_stall) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = '0;
                    end
                end else if (!mem_stall) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // Advisory only: stalling continues regardless.
                    if (wait_cnt_d == WAIT_MAX) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: begin
                // INIT (and any illegal encoding): clear every stage, hold PC.
                pc_en      = 1'b0;
                if_id_clr  = 1'b1;
                id_ex_clr  = 1'b1;
                ex_mem_clr = 1'b1;
                mem_wb_clr = 1'b1;
                if (state_q != INIT) begin
                    state_d = INIT;
                end else if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= INIT;
            flush_cnt_q   <= FLUSH_INIT;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.pc_enable       = pc_en;
    assign bus.if_id_enable    = if_id_en;
    assign bus.id_ex_enable    = id_ex_en;
    assign bus.ex_mem_enable   = ex_mem_en;
    assign bus.mem_wb_enable   = mem_wb_en;
    assign bus.if_id_clear     = if_id_clr;
    assign bus.id_ex_clear     = id_ex_clr;
    assign bus.ex_mem_clear    = ex_mem_clr;
    assign bus.mem_wb_clear    = mem_wb_clr;
    assign bus.mem_timeout_err = timeout_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((state_q == RUN || state_q == MEM_WAIT) && !pc_en) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (branch_flush) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
// Control outputs are packed as
//   {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//    if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}
// Counter checks are compiled in when PIPE_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import control_types::*;

    localparam logic [8:0] C_INIT   = 9'b0_1111_1111;
    localparam logic [8:0] C_NORMAL = 9'b1_1111_0000;
    localparam logic [8:0] C_LU     = 9'b0_0111_0100;
    localparam logic [8:0] C_BRANCH = 9'b1_1111_1100;
    localparam logic [8:0] C_MEMSTL = 9'b0_0001_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] ctrl;
    assign ctrl = {bus.pc_enable, bus.if_id_enable, bus.id_ex_enable,
                   bus.ex_mem_enable, bus.mem_wb_enable, bus.if_id_clear,
                   bus.id_ex_clear, bus.ex_mem_clear, bus.mem_wb_clear};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] wr, input logic wen, input reg_wr_src_t src,
                         input logic br, input logic req, input logic rdy);
        bus.rs1_idx_id           = rs1;
        bus.rs1_used_id          = u1;
        bus.rs2_idx_id           = rs2;
        bus.rs2_used_id          = u2;
        bus.wr_reg_idx_ex        = wr;
        bus.reg_do_write_ctrl_ex = wen;
        bus.reg_wr_src_ctrl_ex   = src;
        bus.branch_taken_ex      = br;
        bus.dmem_req_mem         = req;
        bus.dmem_ready_mem       = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b0, 1'b0);
    endtask

    // Step to just after the next rising edge, apply new inputs later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check the packed controls one nanosecond after inputs settle.
    task automatic check_ctrl(input string tag, input logic [8:0] exp);
        #1;
        $display("[%0t] %s ctrl=%b err=%b", $time, tag, ctrl, bus.mem_timeout_err);
        chk(tag, 32'(ctrl), 32'(exp));
    endtask

    task automatic init_sequence(input string tag);
        chk({tag, "_init0"}, 32'(ctrl), 32'(C_INIT));
`ifdef PIPE_CTRL_PERF_EN
        chk({tag, "_stall0"}, bus.stall_cycles, 32'd0);
        chk({tag, "_flush0"}, bus.flush_count, 32'd0);
`endif
        next_cycle();
        check_ctrl({tag, "_init1"}, C_INIT);
        next_cycle();
        check_ctrl({tag, "_run0"}, C_NORMAL);
    endtask

    initial begin
        idle();
        // --- reset held for three edges ---
        repeat (3) @(posedge clk);
        #2;
        check_ctrl("rst_hold", C_INIT);
        chk("rst_err", 32'(bus.mem_timeout_err), 32'd0);
        rst = 1'b0;
        #1;
        init_sequence("por");

        // --- load-use variants ---
        next_cycle(); drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, WRSRC_MEMREAD, 1'b0, 1'b0, 1'b0);
        check_ctrl("lu_rs1", C_LU);
        next_cycle(); drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, WRSRC_MEMREAD, 1'b0, 1'b0, 1'b0);
        check_ctrl("lu_x0", C_NORMAL);
        next_cycle(); drive(5'd3, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, WRSRC_MEMREAD, 1'b0, 1'b0, 1'b0);
        check_ctrl("lu_rs2", C_LU);
        next_cycle(); drive(5'd3, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, WRSRC_MEMREAD, 1'b0, 1'b0, 1'b0);
        check_ctrl("lu_unused", C_NORMAL);
        next_cycle(); drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, WRSRC_ALU, 1'b0, 1'b0, 1'b0);
        check_ctrl("lu_alu", C_NORMAL);
        next_cycle(); drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, WRSRC_MEMREAD, 1'b1, 1'b0, 1'b0);
        check_ctrl("br_lu", C_BRANCH);

        // --- 3-cycle memory wait with a pending branch ---
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b1, 1'b1, 1'b0);
            check_ctrl($sformatf("mw%0d", k), C_MEMSTL);
        end
        next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b1, 1'b1, 1'b1);
        check_ctrl("mw_release", C_BRANCH);
        next_cycle(); idle();
        check_ctrl("mw_after", C_NORMAL);
        chk("mw_no_err", 32'(bus.mem_timeout_err), 32'd0);
        next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b0, 1'b0);
        check_ctrl("noreq_rdy_low", C_NORMAL);

        // --- watchdog: ready low for 6 cycles ---
        for (int k = 1; k <= 6; k++) begin
            next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b1, 1'b0);
            check_ctrl($sformatf("wd_ctrl%0d", k), C_MEMSTL);
            chk($sformatf("wd_err%0d", k), 32'(bus.mem_timeout_err), 32'(k == 6));
        end
        next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b1, 1'b1);
        check_ctrl("wd_release", C_NORMAL);
        chk("wd_sticky", 32'(bus.mem_timeout_err), 32'd1);

        // --- asynchronous reset in the middle of a stall ---
        next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b1, 1'b0);
        check_ctrl("pre_rst_stall", C_MEMSTL);
        #1 rst = 1'b1;
        check_ctrl("async_rst", C_INIT);
        chk("async_rst_err", 32'(bus.mem_timeout_err), 32'd0);
        idle();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        init_sequence("rst2");

        // --- perf scenario: 1 load-use, 3-cycle wait, 2 branches ---
        next_cycle(); drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, WRSRC_MEMREAD, 1'b0, 1'b0, 1'b0);
        check_ctrl("pf_lu", C_LU);
        next_cycle(); idle();
        check_ctrl("pf_lu_done", C_NORMAL);
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b1, 1'b0);
            check_ctrl($sformatf("pf_mw%0d", k), C_MEMSTL);
        end
        next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b0, 1'b1, 1'b1);
        check_ctrl("pf_mw_release", C_NORMAL);
        for (int k = 1; k <= 2; k++) begin
            next_cycle(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WRSRC_ALU, 1'b1, 1'b0, 1'b0);
            check_ctrl($sformatf("pf_br%0d", k), C_BRANCH);
        end
        next_cycle(); idle();
        check_ctrl("pf_idle", C_NORMAL);
`ifdef PIPE_CTRL_PERF_EN
        chk("pf_stall_cycles", bus.stall_cycles, 32'd4);
        chk("pf_flush_count", bus.flush_count, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Detects load-use hazards, taken-branch redirects and data-memory wait states, and runs a post-reset flush sequence. Includes a memory-wait watchdog and optional performance counters.

## Interface
- FLUSH_CYCLES, 2: cycles spent in INIT clearing all pipeline registers after reset (≥1).
- MEM_TIMEOUT, 255: consecutive MEM wait cycles tolerated before the watchdog error is set (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_idx_id, rs2_idx_id  in  5 each  source register indices of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1 each  the ID instruction actually reads rs1 / rs2.
- wr_reg_idx_ex  in  5  destination index of the instruction in EX.
- reg_do_write_ctrl_ex  in  1  the EX instruction writes the register file.
- reg_wr_src_ctrl_ex  in  reg_wr_src_t  write-back source of the EX instruction.
- branch_taken_ex  in  1  EX resolved a taken branch or jump (PC redirect).
- dmem_req_mem  in  1  the MEM instruction accesses data memory.
- dmem_ready_mem  in  1  data memory completes the access this cycle.
- pc_enable  out  1  PC register load enable.
- if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1 each  pipeline register enables.
- if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear  out  1 each  pipeline register clears. Clear overrides enable.
- mem_timeout_err  out  1  sticky watchdog error.
- stall_cycles  out  32  present only with the macro. Counts cycles with pc_enable=0 in RUN or MEM_WAIT.
- flush_count  out  32  present only with the macro. Counts cycles with branch flush applied.

## Operation
- FSM states: INIT, RUN, MEM_WAIT. rst forces INIT, flush counter = FLUSH_CYCLES-1, mem_timeout_err = 0, perf counters = 0.
- INIT:
  - All four clears = 1, all four enables = 1, pc_enable = 0.
  - Counter decrements each cycle. When it reaches 0, the next state is RUN.
  - These are also the output values while rst is asserted.
- Hazard conditions, evaluated combinationally in RUN and MEM_WAIT:
  - mem_stall = dmem_req_mem & ~dmem_ready_mem.
  - load_use = reg_do_write_ctrl_ex & (reg_wr_src_ctrl_ex == WRSRC_MEMREAD) & (wr_reg_idx_ex != 0) & ((rs1_used_id & rs1_idx_id == wr_reg_idx_ex) | (rs2_used_id & rs2_idx_id == wr_reg_idx_ex)).
- Priority is mem_stall > branch_taken_ex > load_use > normal.
  - mem_stall: pc, if_id, id_ex and ex_mem enables = 0. mem_wb_enable = 1 and mem_wb_clear = 1 (bubble into WB). Branch and load-use are ignored; they persist because EX is frozen.
  - branch_taken_ex: all enables = 1, if_id_clear = 1, id_ex_clear = 1. Any coincident load_use is discarded because the ID instruction is squashed.
  - load_use: pc_enable = 0, if_id_enable = 0, id_ex_clear = 1. All other enables = 1.
  - normal: all enables = 1, all clears = 0.
- State transitions:
  - RUN → MEM_WAIT when mem_stall.
  - MEM_WAIT → RUN on the first cycle with ~mem_stall. That cycle applies the branch/load_use/normal decode.
- Wait counter:
  - Cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
  - If mem_stall is still high when the counter equals MEM_TIMEOUT, mem_timeout_err is set on that edge and held until rst.
  - Stalling continues regardless of the error; the watchdog is advisory only.
- Outputs are combinational from state and inputs; there is no added latency.

## Timing
- Control outputs are valid in the same cycle as the hazard inputs and are sampled by the pipeline registers at the next rising edge.
- Load-use costs exactly 1 bubble cycle. Taken branch costs 2 squashed instructions. A memory stall of N not-ready cycles costs N cycles.
- INIT lasts exactly FLUSH_CYCLES rising edges after rst deasserts. The first pc_enable=1 occurs in cycle FLUSH_CYCLES.
- rst asserted mid-stall: state returns to INIT immediately (asynchronous) and all counters and the error are cleared.
- dmem_ready_mem is ignored when dmem_req_mem = 0.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles and flush_count ports and their 32-bit wrapping counters exist.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package (control_types): reg_wr_src_t, WRSRC_MEMREAD, and a new pipe_ctrl_state_t enum {INIT, RUN, MEM_WAIT}.
- One sub-module: hazard_detect, the purely combinational load_use compare, instantiated once.
- FSM, counters and output decode live in the top module.

## Test plan
- Reset with FLUSH_CYCLES=2: hold rst 3 cycles, release → all clears=1 and pc_enable=0 for 2 edges, then all enables=1 and clears=0.
- Load-use: EX = lw to x7 (WRSRC_MEMREAD), ID reads rs1=7 → pc_enable=0, if_id_enable=0, id_ex_clear=1 for 1 cycle. Same case with wr_reg_idx_ex=0 → no stall.
- Branch plus coincident load-use: branch_taken_ex=1 with load_use true → if_id_clear=id_ex_clear=1, pc_enable=1, and no stall.
- Memory wait: dmem_req=1 with ready low for 3 cycles, then high → 3 cycles of front-end enables=0 and mem_wb_clear=1, then normal. A pending branch_taken_ex is applied on the release cycle.
- Watchdog with MEM_TIMEOUT=4: ready held low for 6 cycles → mem_timeout_err rises after the 4th MEM_WAIT cycle, stays high after ready, and clears only on rst.
- PIPE_CTRL_PERF_EN: 1 load-use, 3-cycle mem wait and 2 branches → stall_cycles=4, flush_count=2.
